// File: rtl/ram_access_arbiter_pkg.sv
// Shared types for the RAM access arbiter: FSM states, RAM command opcodes
// and the one-hot ack encoder.
package ram_access_pkg;

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, RCMD, RWAIT, DONE} state_t;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   function automatic logic [1:0] ack_onehot(input logic g);
      return g ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester-side bus of the RAM access arbiter. Both requesters share one
// packed bus; the arbiter sits on the slave modport.
interface ram_access_arbiter_if #(
   parameter int ADDR_SIZE = 8,
   parameter int DATA_W    = 8
);
   logic [1:0]             req;
   logic [1:0]             we;
   logic [2*ADDR_SIZE-1:0] addr;
   logic [2*DATA_W-1:0]    wdata;
   logic [1:0]             ack;
   logic [DATA_W-1:0]      rdata;
   logic                   err;
   logic                   busy;

   modport master (output req, we, addr, wdata, input ack, rdata, err, busy);
   modport slave  (input req, we, addr, wdata, output ack, rdata, err, busy);
endinterface

// File: rtl/ram_access_arbiter_rr_arbiter2.sv
// Two-way grant encoder. Round-robin on ties by default; with
// RAM_ACCESS_ARB_FIXED_PRIO_EN defined, requester 0 always wins a tie.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       grant_en,
   output logic       grant
);
`ifdef RAM_ACCESS_ARB_FIXED_PRIO_EN
   assign grant = ~req[0];
`else
   logic last_grant;

   assign grant = (req == 2'b11) ? ~last_grant : req[1];

   // Reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= 1'b1;
      else if (grant_en)
         last_grant <= grant;
   end
`endif
endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port RAM between two requesters and turns each granted
// access into the RAM's 10-bit command stream. Option: RAM_ACCESS_ARB_FIXED_PRIO_EN.
//
// state | meaning
// IDLE  | idle word on RAM, waiting for any req
// ADDR  | address command (write or read opcode)
// WDATA | write data command
// RCMD  | read-data request command
// RWAIT | waiting for ram_tx_valid, bounded by TIMEOUT
// DONE  | one-cycle ack to the granted requester
module ram_access_arbiter
   import ram_access_pkg::*;
#(
   parameter int ADDR_SIZE = 8,
   parameter int DATA_W    = 8,
   parameter int TIMEOUT   = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   ram_access_arbiter_if.slave    bus,
   output logic [ADDR_SIZE+1:0]   ram_din,
   output logic                   ram_rx_valid,
   input  logic [DATA_W-1:0]      ram_dout,
   input  logic                   ram_tx_valid
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_SIZE+1:0] IDLE_WORD = {OP_WR_ADDR, {ADDR_SIZE{1'b0}}};

   state_t                 state;
   logic                   grant;
   logic                   grant_en;
   logic                   grant_q;
   logic                   we_q;
   logic [ADDR_SIZE-1:0]   addr_q;
   logic [DATA_W-1:0]      wdata_q;
   logic [CNT_W-1:0]       cnt;
   logic                   sel_we;
   logic [ADDR_SIZE-1:0]   sel_addr;
   logic [DATA_W-1:0]      sel_wdata;

   assign grant_en  = (state == IDLE) && (|bus.req);
   assign sel_we    = grant ? bus.we[1] : bus.we[0];
   assign sel_addr  = grant ? bus.addr[2*ADDR_SIZE-1:ADDR_SIZE] : bus.addr[ADDR_SIZE-1:0];
   assign sel_wdata = grant ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];

   rr_arbiter2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (bus.req),
      .grant_en (grant_en),
      .grant    (grant)
   );

   // Outputs are registered together with the state they belong to, so each
   // branch loads the values for the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         grant_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt          <= '0;
         bus.ack      <= '0;
         bus.rdata    <= '0;
         bus.err      <= 1'b0;
         bus.busy     <= 1'b0;
         ram_din      <= '0;
         ram_rx_valid <= 1'b0;
      end else begin
         bus.ack <= '0;
         case (state)
            IDLE: begin
               if (grant_en) begin
                  grant_q      <= grant;
                  we_q         <= sel_we;
                  addr_q       <= sel_addr;
                  wdata_q      <= sel_wdata;
                  ram_din      <= {sel_we ? OP_WR_ADDR : OP_RD_ADDR, sel_addr};
                  ram_rx_valid <= 1'b1;
                  bus.busy     <= 1'b1;
                  state        <= ADDR;
               end
            end
            ADDR: begin
               ram_rx_valid <= 1'b1;
               if (we_q) begin
                  ram_din <= {OP_WR_DATA, ADDR_SIZE'(wdata_q)};
                  state   <= WDATA;
               end else begin
                  ram_din <= {OP_RD_DATA, {ADDR_SIZE{1'b0}}};
                  state   <= RCMD;
               end
            end
            WDATA: begin
               ram_din      <= IDLE_WORD;
               ram_rx_valid <= 1'b0;
               bus.ack      <= ack_onehot(grant_q);
               state        <= DONE;
            end
            RCMD: begin
               ram_din      <= IDLE_WORD;
               ram_rx_valid <= 1'b0;
               state        <= RWAIT;
            end
            RWAIT: begin
               if (ram_tx_valid) begin
                  bus.rdata <= ram_dout;
                  bus.err   <= 1'b0;
                  bus.ack   <= ack_onehot(grant_q);
                  state     <= DONE;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  bus.rdata <= '0;
                  bus.err   <= 1'b1;
                  bus.ack   <= ack_onehot(grant_q);
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               cnt      <= '0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter with a behavioural SPI-style RAM.
module tb_ram_access_arbiter;
   localparam int TO = 15;

   typedef struct {
      int           id;
      bit           rd;
      logic [7:0]   rdata;
      bit           err;
      int           cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  ram_din;
   logic        ram_rx_valid;
   logic [7:0]  ram_dout = '0;
   logic        ram_tx_valid = 1'b0;
   logic        mute = 1'b0;
   logic [7:0]  mem [256];
   logic [7:0]  wr_addr = '0;
   logic [7:0]  rd_addr = '0;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   exp_t        q[$];
   logic [9:0]  cq[$];

   ram_access_arbiter_if #(.ADDR_SIZE(8), .DATA_W(8)) bus ();

   ram_access_arbiter #(.ADDR_SIZE(8), .DATA_W(8), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_dout     (ram_dout),
      .ram_tx_valid (ram_tx_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: tx_valid is a one-cycle pulse after a read-data command.
   always @(posedge clk) begin
      ram_tx_valid <= 1'b0;
      if (ram_rx_valid) begin
         case (ram_din[9:8])
            2'b00: wr_addr <= ram_din[7:0];
            2'b01: mem[wr_addr] <= ram_din[7:0];
            2'b10: rd_addr <= ram_din[7:0];
            default: begin
               ram_dout     <= mem[rd_addr];
               ram_tx_valid <= !mute;
            end
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: ack and RAM commands checked against the scoreboard queues.
   always @(negedge clk) begin
      exp_t e;
      if (bus.ack != 2'b00) begin
         if (q.size() == 0) begin
            chk("unexpected_ack", {30'd0, bus.ack}, 32'd0);
         end else begin
            e = q.pop_front();
            chk("ack_id", {30'd0, bus.ack}, (e.id == 1) ? 32'd2 : 32'd1);
            chk("ack_cycle", cyc, e.cyc);
            if (e.rd) begin
               chk("rdata", {24'd0, bus.rdata}, {24'd0, e.rdata});
               chk("err", {31'd0, bus.err}, {31'd0, e.err});
            end
         end
      end else if (q.size() != 0 && cyc > q[0].cyc) begin
         e = q.pop_front();
         chk("ack_missing", cyc, e.cyc);
      end
      if (ram_rx_valid) begin
         if (cq.size() == 0)
            chk("unexpected_cmd", {22'd0, ram_din}, 32'h3ff);
         else
            chk("ram_din", {22'd0, ram_din}, {22'd0, cq.pop_front()});
      end
   end

   task automatic push_cmds(input bit wr, input logic [7:0] a, input logic [7:0] d);
      if (wr) begin
         cq.push_back({2'b00, a});
         cq.push_back({2'b01, d});
      end else begin
         cq.push_back({2'b10, a});
         cq.push_back({2'b11, 8'h00});
      end
   endtask

   task automatic drive(input int id, input bit wr, input logic [7:0] a, input logic [7:0] d);
      bus.req[id]          = 1'b1;
      bus.we[id]           = wr;
      bus.addr[id*8 +: 8]  = a;
      bus.wdata[id*8 +: 8] = d;
   endtask

   task automatic do_txn(input int id, input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input bit exp_err, input int lat, input int drop_at);
      exp_t e;
      @(negedge clk);
      drive(id, wr, a, d);
      push_cmds(wr, a, d);
      e.id = id; e.rd = !wr; e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + lat;
      q.push_back(e);
      repeat (drop_at) @(negedge clk);
      bus.req[id] = 1'b0;
      repeat (lat - drop_at) @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ack"},   {30'd0, bus.ack}, 32'd0);
      chk({tag, "_rdata"}, {24'd0, bus.rdata}, 32'd0);
      chk({tag, "_err"},   {31'd0, bus.err}, 32'd0);
      chk({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
      chk({tag, "_din"},   {22'd0, ram_din}, 32'd0);
      chk({tag, "_rxv"},   {31'd0, ram_rx_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   id;
      logic [7:0] rd20;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;

      // Both requesters hold write requests: four grants, alternating from 0.
      @(negedge clk);
      drive(0, 1'b1, 8'h10, 8'h11);
      drive(1, 1'b1, 8'h20, 8'h22);
      for (int k = 0; k < 4; k++) begin
`ifdef RAM_ACCESS_ARB_FIXED_PRIO_EN
         id = 0;
`else
         id = k % 2;
`endif
         push_cmds(1'b1, (id == 1) ? 8'h20 : 8'h10, (id == 1) ? 8'h22 : 8'h11);
         e.id = id; e.rd = 1'b0; e.rdata = '0; e.err = 1'b0; e.cyc = cyc + 3 + 4 * k;
         q.push_back(e);
      end
      repeat (15) @(negedge clk);
      bus.req = 2'b00;

`ifdef RAM_ACCESS_ARB_FIXED_PRIO_EN
      rd20 = 8'h00;
`else
      rd20 = 8'h22;
`endif
      do_txn(0, 1'b0, 8'h10, 8'h00, 8'h11, 1'b0, 4, 4);
      do_txn(1, 1'b0, 8'h20, 8'h00, rd20, 1'b0, 4, 4);

      // Write then read back from requester 0.
      do_txn(0, 1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0, 3, 3);
      do_txn(0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 4, 4);

      // RAM never answers: abort after TIMEOUT+1 cycles in RWAIT.
      mute = 1'b1;
      do_txn(1, 1'b0, 8'h55, 8'h00, 8'h00, 1'b1, 4 + TO, 4 + TO);
      mute = 1'b0;
      do_txn(0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 4, 4);

      // Reset while the read-data command is on the RAM bus.
      @(negedge clk);
      drive(0, 1'b0, 8'h10, 8'h00);
      push_cmds(1'b0, 8'h10, 8'h00);
      @(negedge clk);
      @(negedge clk);
      chk("rcmd_busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("midreset");
      rst = 1'b0;
      bus.req = 2'b00;
      do_txn(1, 1'b0, 8'h10, 8'h00, 8'h11, 1'b0, 4, 4);

      // Requester 1 drops req during ADDR; the write must still complete.
      do_txn(1, 1'b1, 8'h77, 8'h5A, 8'h00, 1'b0, 3, 1);
      do_txn(0, 1'b0, 8'h77, 8'h00, 8'h5A, 1'b0, 4, 4);

      repeat (6) @(negedge clk);
      chk("ack_queue_empty", q.size(), 32'd0);
      chk("cmd_queue_empty", cq.size(), 32'd0);
      chk("mem_77", {24'd0, mem[8'h77]}, 32'h5A);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
